// File: rtl/cim_accum_bank.sv
// Addressed accumulator bank: ROWS signed words sharing one read-modify-write adder,
// with single-cycle write/read/row-clear and FSM-sequenced accumulate and full-bank clear.
module cim_accum_bank #(
    parameter int unsigned ROWS     = 8,
    parameter int unsigned WIDTH    = 16,
    parameter int unsigned ADDR_W   = $clog2(ROWS),
    parameter int unsigned SATURATE = 1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              cmd_valid,
    output logic              cmd_ready,
    input  logic [2:0]        cmd_op,
    input  logic [ADDR_W-1:0] cmd_addr,
    input  logic [WIDTH-1:0]  cmd_data,
    output logic              rd_valid,
    output logic [WIDTH-1:0]  rd_data,
    output logic              busy,
    output logic              ovf
);

    localparam logic [2:0] OP_WRITE   = 3'd1;
    localparam logic [2:0] OP_READ    = 3'd2;
    localparam logic [2:0] OP_ACCUM   = 3'd3;
    localparam logic [2:0] OP_CLR_ROW = 3'd4;
    localparam logic [2:0] OP_CLR_ALL = 3'd5;

    localparam logic [WIDTH-1:0] SAT_MAX = {1'b0, {(WIDTH-1){1'b1}}};
    localparam logic [WIDTH-1:0] SAT_MIN = {1'b1, {(WIDTH-1){1'b0}}};

    typedef enum logic [1:0] {
        IDLE      = 2'd0,
        ACC_WB    = 2'd1,
        CLR_SWEEP = 2'd2
    } state_t;

    state_t state;
    state_t state_next;

    logic [WIDTH-1:0]  rows [ROWS];
    logic [WIDTH:0]    sum_q;
    logic [ADDR_W-1:0] acc_addr;
    logic [ADDR_W-1:0] sweep_cnt;

    logic              accept_c;
    logic [WIDTH-1:0]  rd_word_c;
    logic [WIDTH:0]    acc_sum_c;
    logic              acc_ovf_c;
    logic [WIDTH-1:0]  acc_result_c;

    logic              wr_en_c;
    logic [ADDR_W-1:0] wr_addr_c;
    logic [WIDTH-1:0]  wr_data_c;
    logic              ovf_set_c;
    logic              ovf_clr_c;

    assign accept_c  = cmd_valid && cmd_ready;
    assign rd_word_c = rows[cmd_addr];
    assign acc_sum_c = {rd_word_c[WIDTH-1], rd_word_c} + {cmd_data[WIDTH-1], cmd_data};

    // Signed overflow shows up as disagreement between the two top bits of the extended sum.
    always_comb begin
        acc_ovf_c    = sum_q[WIDTH] ^ sum_q[WIDTH-1];
        acc_result_c = sum_q[WIDTH-1:0];
        if (SATURATE != 0 && acc_ovf_c) begin
            acc_result_c = sum_q[WIDTH] ? SAT_MIN : SAT_MAX;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Next state plus the single row write port shared by every command.
    always_comb begin
        state_next = state;
        wr_en_c    = 1'b0;
        wr_addr_c  = cmd_addr;
        wr_data_c  = '0;
        ovf_set_c  = 1'b0;
        ovf_clr_c  = 1'b0;
        case (state)
            IDLE: begin
                if (accept_c) begin
                    case (cmd_op)
                        OP_WRITE: begin
                            wr_en_c   = 1'b1;
                            wr_data_c = cmd_data;
                        end
                        OP_ACCUM:   state_next = ACC_WB;
                        OP_CLR_ROW: wr_en_c = 1'b1;
                        OP_CLR_ALL: state_next = CLR_SWEEP;
                        default:    ;
                    endcase
                end
            end
            ACC_WB: begin
                wr_en_c    = 1'b1;
                wr_addr_c  = acc_addr;
                wr_data_c  = acc_result_c;
                ovf_set_c  = acc_ovf_c;
                state_next = IDLE;
            end
            CLR_SWEEP: begin
                wr_en_c   = 1'b1;
                wr_addr_c = sweep_cnt;
                if (sweep_cnt == ADDR_W'(ROWS - 1)) begin
                    ovf_clr_c  = 1'b1;
                    state_next = IDLE;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < int'(ROWS); i++) begin
                rows[i] <= '0;
            end
            sum_q     <= '0;
            acc_addr  <= '0;
            sweep_cnt <= '0;
            cmd_ready <= 1'b1;
            busy      <= 1'b0;
            rd_valid  <= 1'b0;
            rd_data   <= '0;
            ovf       <= 1'b0;
        end else begin
            if (wr_en_c) begin
                rows[wr_addr_c] <= wr_data_c;
            end
            cmd_ready <= (state_next == IDLE);
            busy      <= (state_next != IDLE);
            rd_valid  <= accept_c && (cmd_op == OP_READ);
            if (accept_c && cmd_op == OP_READ) begin
                rd_data <= rd_word_c;
            end
            if (accept_c && cmd_op == OP_ACCUM) begin
                sum_q    <= acc_sum_c;
                acc_addr <= cmd_addr;
            end
            if (accept_c && cmd_op == OP_CLR_ALL) begin
                sweep_cnt <= '0;
            end else if (state == CLR_SWEEP) begin
                sweep_cnt <= sweep_cnt + ADDR_W'(1);
            end
            if (ovf_clr_c) begin
                ovf <= 1'b0;
            end else if (ovf_set_c) begin
                ovf <= 1'b1;
            end
        end
    end

endmodule
